// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: PC-register link, instruction-memory request/response
// and the decode-side valid/ready payload.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              pc_en_o;
  logic              flush_i;
  logic              inst_req_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_addr_ok_i;
  logic              inst_data_ok_i;
  logic [DATA_W-1:0] inst_rdata_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
  logic              id_adel_o;

  modport master (
    input  pc_i, flush_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, id_ready_i,
    output pc_en_o, inst_req_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o
  );

  modport slave (
    output pc_i, flush_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, id_ready_i,
    input  pc_en_o, inst_req_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding memory request at a time, holds the
// fetched {pc, inst} for decode and drops fetches overtaken by a flush.
module inst_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              discard_q;
  logic              id_valid_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [DATA_W-1:0] id_inst_q;
  logic              id_adel_q;

  logic aligned_c;
  logic req_c;
  logic pc_en_c;

  assign aligned_c = (bus.pc_i[1:0] == 2'b00);

  // Request and PC advance react to addr_ok in the same cycle; both are gated by reset.
  always_comb begin
    req_c   = 1'b0;
    pc_en_c = 1'b0;
    if (rst && (state_q == S_REQ) && !bus.flush_i) begin
      if (aligned_c) begin
        req_c   = 1'b1;
        pc_en_c = bus.inst_addr_ok_i;
      end else begin
        pc_en_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      addr_q     <= '0;
      discard_q  <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_adel_q  <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!bus.flush_i) begin
            if (aligned_c) begin
              if (bus.inst_addr_ok_i) begin
                addr_q  <= bus.pc_i;
                state_q <= S_WAIT;
              end
            end else begin
              // Misaligned PC never reaches memory; the fault travels to decode instead.
              id_pc_q    <= bus.pc_i;
              id_inst_q  <= '0;
              id_adel_q  <= 1'b1;
              id_valid_q <= 1'b1;
              state_q    <= S_FULL;
            end
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok_i) begin
            if (!discard_q && !bus.flush_i) begin
              id_pc_q    <= addr_q;
              id_inst_q  <= bus.inst_rdata_i;
              id_adel_q  <= 1'b0;
              id_valid_q <= 1'b1;
              state_q    <= S_FULL;
            end else begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
            end
          end else if (bus.flush_i) begin
            discard_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (bus.flush_i) begin
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
            state_q    <= S_REQ;
          end else if (bus.id_ready_i) begin
            id_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign bus.inst_req_o  = req_c;
  assign bus.pc_en_o     = pc_en_c;
  assign bus.inst_addr_o = bus.pc_i;
  assign bus.id_valid_o  = id_valid_q;
  assign bus.id_pc_o     = id_pc_q;
  assign bus.id_inst_o   = id_inst_q;
  assign bus.id_adel_o   = id_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_inst_fetch;
  logic clk;
  logic rst;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: a request in flight, a poisoned flag, and one held payload.
  logic [31:0] pc;
  bit          m_busy, m_drop, m_have, m_adel, acc;
  logic [31:0] m_baddr, m_hpc, m_hinst;
  logic        e_req, e_pc_en;
  logic        s_req, s_pc_en, s_valid, s_adel;
  logic [31:0] s_addr, s_pc, s_inst;
  int          mem_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic sample();
    s_req   = bus.inst_req_o;
    s_pc_en = bus.pc_en_o;
    s_valid = bus.id_valid_o;
    s_adel  = bus.id_adel_o;
    s_addr  = bus.inst_addr_o;
    s_pc    = bus.id_pc_o;
    s_inst  = bus.id_inst_o;
  endtask

  task automatic step(input bit f, input logic [31:0] tgt, input bit aok, input bit dok,
                      input logic [31:0] rd, input bit rdy);
    bit idle;
    @(negedge clk);
    if (f) pc = tgt;
    bus.pc_i           = pc;
    bus.flush_i        = f;
    bus.inst_addr_ok_i = aok;
    bus.inst_data_ok_i = dok;
    bus.inst_rdata_i   = rd;
    bus.id_ready_i     = rdy;
    idle    = !m_busy && !m_have;
    e_req   = idle && !f && (pc[1:0] == 2'b00);
    e_pc_en = idle && !f && ((pc[1:0] != 2'b00) || aok);
    #4;
    sample();
    chk("req", 32'(s_req), 32'(e_req));
    chk("pc_en", 32'(s_pc_en), 32'(e_pc_en));
    chk("id_valid", 32'(s_valid), 32'(m_have));
    if (e_req) chk("inst_addr", s_addr, pc);
    if (m_have) begin
      chk("id_pc", s_pc, m_hpc);
      chk("id_inst", s_inst, m_hinst);
      chk("id_adel", 32'(s_adel), 32'(m_adel));
    end
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (idle) begin
      if (!f) begin
        if (pc[1:0] != 2'b00) begin
          m_have = 1'b1; m_hpc = pc; m_hinst = '0; m_adel = 1'b1;
        end else if (aok) begin
          m_busy = 1'b1; m_baddr = pc; acc = 1'b1;
        end
      end
    end else if (m_busy) begin
      if (dok) begin
        m_busy = 1'b0;
        if (!m_drop && !f) begin
          m_have = 1'b1; m_hpc = m_baddr; m_hinst = rd; m_adel = 1'b0;
        end
        m_drop = 1'b0;
      end else if (f) begin
        m_drop = 1'b1;
      end
    end else if (f || rdy) begin
      m_have = 1'b0;
    end
    if (e_pc_en) pc = pc + 32'd4;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    bit          f, aok, dok, rdy;
    logic [31:0] tgt, rd;

    m_busy = 0; m_drop = 0; m_have = 0; m_adel = 0; acc = 0;
    m_baddr = '0; m_hpc = '0; m_hinst = '0;
    pc = 32'hBFC0_0000;
    rst = 1'b0;
    bus.pc_i = pc; bus.flush_i = 0; bus.inst_addr_ok_i = 0; bus.inst_data_ok_i = 0;
    bus.inst_rdata_i = '0; bus.id_ready_i = 0;

    // Reset values while held
    #2; bus.inst_addr_ok_i = 1'b1; #1;
    sample();
    lit("rst_req", 32'(s_req), 32'd0);
    lit("rst_pc_en", 32'(s_pc_en), 32'd0);
    lit("rst_valid", 32'(s_valid), 32'd0);
    lit("rst_id_pc", s_pc, 32'd0);
    lit("rst_id_inst", s_inst, 32'd0);
    lit("rst_adel", 32'(s_adel), 32'd0);
    bus.inst_addr_ok_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // First fetch: accept same cycle, data one cycle later
    step(0, 0, 1, 0, 0, 0);
    lit("boot_req", 32'(s_req), 32'd1);
    lit("boot_addr", s_addr, 32'hBFC0_0000);
    lit("boot_pc_en", 32'(s_pc_en), 32'd1);
    step(0, 0, 0, 1, 32'h3C08_0001, 0);
    lit("wait_pc_en", 32'(s_pc_en), 32'd0);
    lit("wait_req", 32'(s_req), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    lit("boot_valid", 32'(s_valid), 32'd1);
    lit("boot_id_pc", s_pc, 32'hBFC0_0000);
    lit("boot_id_inst", s_inst, 32'h3C08_0001);
    lit("boot_adel", 32'(s_adel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0);
      lit("hold_valid", 32'(s_valid), 32'd1);
      lit("hold_inst", s_inst, 32'h3C08_0001);
      lit("hold_req", 32'(s_req), 32'd0);
    end
    step(0, 0, 0, 0, 0, 1);

    // addr_ok withheld three cycles then granted
    for (int i = 0; i < 4; i++) begin
      step(0, 0, (i == 3), 0, 0, 0);
      lit("stall_req", 32'(s_req), 32'd1);
      lit("stall_addr", s_addr, 32'hBFC0_0004);
      lit("stall_pc_en", 32'(s_pc_en), (i == 3) ? 32'd1 : 32'd0);
    end

    // Flush while waiting: late data dropped, refetch from new PC
    step(1, 32'hBFC0_0380, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    step(0, 0, 1, 0, 0, 0);
    lit("flush_valid", 32'(s_valid), 32'd0);
    lit("flush_req", 32'(s_req), 32'd1);
    lit("flush_addr", s_addr, 32'hBFC0_0380);
    // Flush coincident with data_ok
    step(1, 32'hBFC0_0400, 0, 1, 32'hCAFE_F00D, 1);
    step(0, 0, 0, 0, 0, 0);
    lit("coinc_valid", 32'(s_valid), 32'd0);
    lit("coinc_addr", s_addr, 32'hBFC0_0400);

    // Flush in REQ, then misaligned fetch
    step(1, 32'hBFC0_0002, 1, 0, 0, 0);
    lit("reqflush_req", 32'(s_req), 32'd0);
    lit("reqflush_pc_en", 32'(s_pc_en), 32'd0);
    step(0, 0, 1, 0, 0, 0);
    lit("adel_req", 32'(s_req), 32'd0);
    lit("adel_pc_en", 32'(s_pc_en), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    lit("adel_valid", 32'(s_valid), 32'd1);
    lit("adel_flag", 32'(s_adel), 32'd1);
    lit("adel_inst", s_inst, 32'd0);
    lit("adel_id_pc", s_pc, 32'hBFC0_0002);
    step(1, 32'hBFC0_0010, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    lit("fullflush_valid", 32'(s_valid), 32'd0);
    lit("fullflush_addr", s_addr, 32'hBFC0_0010);

    // Reset in WAIT after a flush poisoned the fetch
    step(1, 32'hBFC0_0020, 0, 0, 0, 0);
    @(negedge clk);
    bus.flush_i = 0; bus.inst_addr_ok_i = 0; bus.inst_data_ok_i = 0;
    #2; rst = 1'b0; #1;
    sample();
    lit("midrst_req", 32'(s_req), 32'd0);
    lit("midrst_pc_en", 32'(s_pc_en), 32'd0);
    lit("midrst_valid", 32'(s_valid), 32'd0);
    lit("midrst_id_pc", s_pc, 32'd0);
    lit("midrst_id_inst", s_inst, 32'd0);
    lit("midrst_adel", 32'(s_adel), 32'd0);
    m_busy = 0; m_drop = 0; m_have = 0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 0, 0, 0);
    lit("post_rst_req", 32'(s_req), 32'd1);
    lit("post_rst_addr", s_addr, 32'hBFC0_0020);
    step(0, 0, 0, 1, 32'h1234_5678, 0);
    step(0, 0, 0, 0, 0, 1);
    lit("post_rst_valid", 32'(s_valid), 32'd1);
    lit("post_rst_inst", s_inst, 32'h1234_5678);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      f   = ($urandom % 16) == 0;
      tgt = {16'hBFC0, 16'($urandom)} & 32'hFFFF_FFFC;
      if (($urandom % 8) == 0) tgt = tgt | 32'd2;
      aok = ($urandom % 2) == 0;
      rdy = ($urandom % 2) == 0;
      rd  = $urandom;
      if (mem_cnt == 1) begin
        dok = 1'b1; mem_cnt = 0;
      end else if (mem_cnt > 1) begin
        dok = 1'b0; mem_cnt--;
      end else begin
        dok = !m_busy && (($urandom % 8) == 0);
      end
      step(f, tgt, aok, dok, rd, rdy);
      if (acc) mem_cnt = int'($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
